bias_requant_pipe: RTL

//  Per-channel bias add with requantisation for the layer datapath; generalises the fixed 8-bit bias adder.

---
 rtl/bias_requant_pipe_pkg.sv | 36 +++
 rtl/bias_requant_pipe_lane.sv | 79 +++++++
 rtl/bias_requant_pipe.sv | 102 ++++++++++
 3 files changed

// File: rtl/bias_requant_pipe_pkg.sv
// Shared helpers for the bias/requant datapath: rounding constant, clamp bounds, clamp and saturation detect.
package bias_pkg;

  localparam int DEF_NUM_CH = 16;
  localparam int CH_W       = $clog2(DEF_NUM_CH);

  // Constant added before the right shift; zero when truncating or not shifting.
  function automatic logic [63:0] rnd_const(input int shift, input int round_en);
    if ((round_en != 0) && (shift > 0)) return 64'd1 << (shift - 1);
    return '0;
  endfunction

  function automatic logic signed [63:0] clamp_hi(input bit is_signed, input int data_w);
    if (is_signed) return (64'sd1 <<< (data_w - 1)) - 64'sd1;
    return (64'sd1 <<< data_w) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] clamp_lo(input bit is_signed, input int data_w);
    if (is_signed) return -(64'sd1 <<< (data_w - 1));
    return 64'sd0;
  endfunction

  // Clamp a wide intermediate into the data_w range (signed or unsigned).
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                   input bit is_signed, input int data_w);
    if (value > clamp_hi(is_signed, data_w)) return clamp_hi(is_signed, data_w);
    if (value < clamp_lo(is_signed, data_w)) return clamp_lo(is_signed, data_w);
    return value;
  endfunction

  // High when sat_clamp would have changed the value.
  function automatic bit sat_hit(input logic signed [63:0] value, input bit is_signed, input int data_w);
    return (value > clamp_hi(is_signed, data_w)) || (value < clamp_lo(is_signed, data_w));
  endfunction

endpackage

// File: rtl/bias_requant_pipe_lane.sv
// One lane: stage 1 adds activation and bias, stage 2 rounds, shifts and clamps.
module bias_lane_requant
  import bias_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BIAS_W = 8,
  parameter int SHIFT  = 1,
  parameter int SIGNED = 0,
  parameter int ROUND  = 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              en1_i,
  input  logic              en2_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [BIAS_W-1:0] b_i,
  output logic [DATA_W-1:0] data_o,
  output logic              sat_o
);

  localparam int             RW  = DATA_W + 2;
  localparam logic [RW-1:0]  RND = RW'(rnd_const(SHIFT, ROUND));

  logic [DATA_W:0]   a_ext, b_ext, sum_d, sum_q;
  logic [RW-1:0]     pre, shifted;
  logic [63:0]       r64;
  logic [DATA_W-1:0] data_d, data_q;
  logic              sat_d, sat_q;

  // Stage 1: extend both operands by one bit and add; the sum cannot overflow DATA_W+1.
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    if (SIGNED != 0) begin
      a_ext = {a_i[DATA_W-1], a_i};
      b_ext = {{(DATA_W + 1 - BIAS_W){b_i[BIAS_W-1]}}, b_i};
    end else begin
      a_ext = {1'b0, a_i};
      b_ext = {{(DATA_W + 1 - BIAS_W){1'b0}}, b_i};
    end
    sum_d = a_ext + b_ext;
  end

  // Stage 2: round, shift (arithmetic when signed), then clamp into the output range.
  always_comb begin
    pre     = '0;
    shifted = '0;
    if (SIGNED != 0) begin
      pre     = {sum_q[DATA_W], sum_q} + RND;
      shifted = RW'($signed(pre) >>> SHIFT);
      r64     = {{(64 - RW){shifted[RW-1]}}, shifted};
    end else begin
      pre     = {1'b0, sum_q} + RND;
      shifted = pre >> SHIFT;
      r64     = {{(64 - RW){1'b0}}, shifted};
    end
    data_d = DATA_W'(sat_clamp(r64, SIGNED != 0, DATA_W));
    sat_d  = sat_hit(r64, SIGNED != 0, DATA_W);
  end

  // Pipeline registers: stage 1 loads on accept, stage 2 loads when stage 1 holds a beat that moves.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sum_q  <= '0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      if (en1_i) sum_q <= sum_d;
      if (en2_i) begin
        data_q <= data_d;
        sat_q  <= sat_d;
      end
    end
  end

  assign data_o = data_q;
  assign sat_o  = sat_q;

endmodule

// File: rtl/bias_requant_pipe.sv
// Per-channel bias add and requantise, SIZE lanes, two-stage valid/ready pipeline.
// Handshake: a beat moves on a side when valid && ready. The whole pipe advances when
// out_ready || !out_valid; in_ready equals that advance, so out_valid/out_data/out_sat/out_ch
// stay stable while out_valid && !out_ready.
module bias_requant_pipe
  import bias_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int DATA_W = 8,
  parameter int BIAS_W = 8,
  parameter int NUM_CH = 16,
  parameter int SHIFT  = 1,
  parameter int SIGNED = 0,
  parameter int ROUND  = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SIZE*DATA_W-1:0]    in_data,
  input  logic                      ch_clear,
  input  logic                      bias_we,
  input  logic [$clog2(NUM_CH)-1:0] bias_addr,
  input  logic [SIZE*BIAS_W-1:0]    bias_wdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SIZE*DATA_W-1:0]    out_data,
  output logic [SIZE-1:0]           out_sat,
  output logic [$clog2(NUM_CH)-1:0] out_ch
);

  localparam int CW = $clog2(NUM_CH);

  logic [SIZE*BIAS_W-1:0] bias_mem [NUM_CH];
  logic [SIZE*BIAS_W-1:0] bias_rd;
  logic [CW-1:0]          ch_d, ch_q, ch1_q, out_ch_q;
  logic                   v1_q, out_valid_q;
  logic                   advance, accept, load2;

  assign advance  = out_ready || !out_valid_q;
  assign accept   = in_valid && advance;
  assign load2    = advance && v1_q;
  assign in_ready = advance;
  assign bias_rd  = bias_mem[ch_q];

  // Bias table, no reset; a read in the write cycle returns the old entry.
  always_ff @(posedge clock) begin
    if (bias_we) bias_mem[bias_addr] <= bias_wdata;
  end

  // Next channel: clear wins, otherwise step and wrap on each accepted beat.
  always_comb begin
    ch_d = ch_q;
    if (ch_clear) begin
      ch_d = '0;
    end else if (accept) begin
      ch_d = (ch_q == CW'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
    end
  end

  // Channel counter, stage valids and the channel carried alongside each beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      ch_q        <= '0;
      ch1_q       <= '0;
      out_ch_q    <= '0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      ch_q <= ch_d;
      if (accept) ch1_q <= ch_q;
      if (load2) out_ch_q <= ch1_q;
      if (advance) begin
        v1_q        <= in_valid;
        out_valid_q <= v1_q;
      end
    end
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    bias_lane_requant #(
      .DATA_W (DATA_W),
      .BIAS_W (BIAS_W),
      .SHIFT  (SHIFT),
      .SIGNED (SIGNED),
      .ROUND  (ROUND)
    ) u_lane (
      .clock_i (clock),
      .reset_i (reset),
      .en1_i   (accept),
      .en2_i   (load2),
      .a_i     (in_data[i*DATA_W +: DATA_W]),
      .b_i     (bias_rd[i*BIAS_W +: BIAS_W]),
      .data_o  (out_data[i*DATA_W +: DATA_W]),
      .sat_o   (out_sat[i])
    );
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule
